// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter and fetch control. It sequences IDLE, RUN
// and HALTED, applies taken relative branches and counts retired instructions.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high; returns to IDLE and clears all state
//   start         begins execution from IDLE or HALTED (ignored in RUN)
//   halt          halt instruction decoded at the current pc
//   stall         holds pc and retired for this cycle
//   branch_en     branch instruction decoded at the current pc
//   branch_cond   branch condition; the branch is taken when this is 1
//   branch_offset signed 8-bit pc-relative branch offset
//   pc            current instruction address (registered)
//   fetch_valid   pc is a live fetch address (state RUN)
//   done          program halted; held until start or reset
//   retired       saturating count of retired instructions
module fetch_sequencer #(
    parameter int PC_WIDTH   = 10,
    parameter int START_ADDR = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    input  logic                stall,
    input  logic                branch_en,
    input  logic                branch_cond,
    input  logic [7:0]          branch_offset,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                done,
    output logic [15:0]         retired
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } state_t;

    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

    state_t              state;
    logic [PC_WIDTH-1:0] offset_ext;
    logic [PC_WIDTH-1:0] pc_branch;
    logic [PC_WIDTH-1:0] pc_next_seq;
    logic [15:0]         retired_inc;
    logic                taken;

    // The signed cast makes the width extension replicate the sign bit.
    // Carries out of the top pc bit are dropped, so branches wrap.
    assign offset_ext  = PC_WIDTH'(signed'(branch_offset));
    assign pc_branch   = pc + offset_ext;
    assign pc_next_seq = pc + PC_WIDTH'(1);
    assign taken       = branch_en && branch_cond;

    // The count sticks at all-ones instead of wrapping.
    assign retired_inc = (retired == 16'hFFFF) ? retired : retired + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            retired     <= '0;
        end else begin
            unique case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= START_PC;
                        retired     <= '0;
                        fetch_valid <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                RUN: begin
                    // Halt wins over stall, and the halt itself retires.
                    if (halt) begin
                        state       <= HALTED;
                        fetch_valid <= 1'b0;
                        done        <= 1'b1;
                        retired     <= retired_inc;
                    end else if (!stall) begin
                        pc      <= taken ? pc_branch : pc_next_seq;
                        retired <= retired_inc;
                    end
                end
                default: begin
                    state       <= IDLE;
                    fetch_valid <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
// (PC_WIDTH=10, START_ADDR=0).
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       halt;
    logic       stall;
    logic       branch_en;
    logic       branch_cond;
    logic [7:0] branch_offset;
    logic [9:0] pc;
    logic       fetch_valid;
    logic       done;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .PC_WIDTH  (10),
        .START_ADDR(0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .halt         (halt),
        .stall        (stall),
        .branch_en    (branch_en),
        .branch_cond  (branch_cond),
        .branch_offset(branch_offset),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .done         (done),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int exp_pc,
                             input int exp_fv, input int exp_done,
                             input int exp_ret);
        chk({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(exp_fv));
        chk({tag, ".done"}, 32'(done), 32'(exp_done));
        chk({tag, ".retired"}, 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        halt = 1'b0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_cond = 1'b0;
        branch_offset = 8'h00;
        step(2);
        chk_state("reset", 0, 0, 0, 0);

        reset = 1'b0;
        start = 1'b1;
        step(1);
        chk_state("start", 0, 1, 0, 0);
        start = 1'b0;
        step(5);
        chk_state("inc5", 5, 1, 0, 5);

        step(15);
        chk_state("at20", 20, 1, 0, 20);
        branch_en = 1'b1;
        branch_cond = 1'b1;
        branch_offset = 8'hFB;
        step(1);
        chk_state("br_taken", 15, 1, 0, 21);
        branch_en = 1'b0;
        branch_cond = 1'b0;
        step(5);
        branch_en = 1'b1;
        branch_offset = 8'hFB;
        step(1);
        chk_state("br_untaken", 21, 1, 0, 27);
        branch_en = 1'b0;

        start = 1'b1;
        step(1);
        chk_state("start_in_run", 22, 1, 0, 28);
        start = 1'b0;

        branch_en = 1'b1;
        branch_cond = 1'b1;
        branch_offset = 8'hF1;
        step(1);
        chk_state("br_to7", 7, 1, 0, 29);
        stall = 1'b1;
        branch_offset = 8'h10;
        step(1);
        chk_state("stall1", 7, 1, 0, 29);
        step(2);
        chk_state("stall3", 7, 1, 0, 29);
        halt = 1'b1;
        step(1);
        chk_state("halt_stall", 7, 0, 1, 30);
        halt = 1'b0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_cond = 1'b0;
        step(2);
        chk_state("halted_hold", 7, 0, 1, 30);

        start = 1'b1;
        step(1);
        chk_state("restart", 0, 1, 0, 0);
        start = 1'b0;

        step(2);
        branch_en = 1'b1;
        branch_cond = 1'b1;
        branch_offset = 8'h80;
        step(1);
        chk_state("br_neg128", 898, 1, 0, 3);
        branch_offset = 8'h7D;
        step(1);
        chk_state("br_pos125", 1023, 1, 0, 4);
        branch_en = 1'b0;
        branch_cond = 1'b0;
        step(1);
        chk_state("inc_wrap", 0, 1, 0, 5);

        branch_en = 1'b1;
        branch_cond = 1'b1;
        branch_offset = 8'h28;
        step(1);
        chk_state("at40", 40, 1, 0, 6);
        branch_offset = 8'h05;
        reset = 1'b1;
        start = 1'b1;
        step(1);
        chk_state("reset_run", 0, 0, 0, 0);
        reset = 1'b0;
        start = 1'b0;
        branch_en = 1'b0;
        branch_cond = 1'b0;
        halt = 1'b1;
        step(1);
        chk_state("idle_ignore", 0, 0, 0, 0);
        halt = 1'b0;

        start = 1'b1;
        step(1);
        start = 1'b0;
        step(65534);
        chk_state("near_sat", 1022, 1, 0, 16'hFFFE);
        step(1);
        chk_state("sat1", 1023, 1, 0, 16'hFFFF);
        step(2);
        chk_state("sat3", 1, 1, 0, 16'hFFFF);
        halt = 1'b1;
        step(1);
        chk_state("sat_halt", 1, 0, 1, 16'hFFFF);
        halt = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
